// File: rtl/vga_fetcher_pkg.sv
// Shared display and memory parameters for the VGA fetch path.
// The fetcher and its pixel FIFO both import this package.
package vga_fetcher_pkg;

  localparam int LOG_MEM        = 16;
  localparam int LOG_HCOUNT     = 10;
  localparam int LOG_VCOUNT     = 9;
  localparam int IMAGE_WIDTH_D2 = 320;
  localparam int IMAGE_LENGTH   = 480;

  typedef logic [LOG_MEM-1:0] mem_word_t;

endpackage

// File: rtl/vga_fetcher_pixel_fifo.sv
// Synchronous pixel-word FIFO with a show-ahead head, flush input and occupancy count.
// When empty the head output holds the last word it presented.
module pixel_fifo
  import vga_fetcher_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   clear,
  input  logic                   push,
  input  logic                   pop,
  input  mem_word_t              din,
  output mem_word_t              dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);

  mem_word_t       mem_q [DEPTH];
  mem_word_t       mem_d [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  mem_word_t       last_q, last_d;
  logic            do_pop;

  assign empty  = (count_q == '0);
  assign count  = count_q;
  assign dout   = empty ? last_q : mem_q[rd_ptr_q];
  assign do_pop = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    last_d   = dout;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + (AW+1)'(push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      last_q   <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      last_q   <= last_d;
    end
  end

endmodule

// File: rtl/vga_fetcher.sv
// Credit-based frame fetcher: walks the image two pixels per read request and
// buffers returned words, tagged by a fixed-latency shift register, in a pixel FIFO.
module vga_fetcher
  import vga_fetcher_pkg::*;
#(
  parameter int FIFO_DEPTH   = 8,
  parameter int READ_LATENCY = 2,
  parameter int IMG_W        = 2 * IMAGE_WIDTH_D2,
  parameter int IMG_H        = IMAGE_LENGTH
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  frame_start,
  output logic                  vga_flag,
  input  logic                  done_vga,
  output logic [LOG_HCOUNT-1:0] hcount,
  output logic [LOG_VCOUNT-1:0] vcount,
  input  logic [LOG_MEM-1:0]    vga_pixel,
  input  logic                  pix_ready,
  output logic [LOG_MEM-1:0]    pix_data,
  output logic                  pix_valid,
  output logic                  underflow
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_e;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int IW = $clog2(READ_LATENCY + 1);
  localparam logic [LOG_HCOUNT-1:0] H_LAST = LOG_HCOUNT'(IMG_W - 2);
  localparam logic [LOG_VCOUNT-1:0] V_LAST = LOG_VCOUNT'(IMG_H - 1);

  state_e                  state_q, state_d;
  logic [LOG_HCOUNT-1:0]   hcount_q, hcount_d;
  logic [LOG_VCOUNT-1:0]   vcount_q, vcount_d;
  logic [READ_LATENCY-1:0] tag_q, tag_d;
  logic                    underflow_q, underflow_d;
  logic [IW-1:0]           in_flight;
  logic [CW-1:0]           fifo_count;
  logic                    fifo_empty;
  logic [31:0]             occupancy;
  logic                    credit;
  logic                    grant;
  logic                    last_req;
  logic                    push;
  logic                    pop;

  always_comb begin
    in_flight = '0;
    for (int i = 0; i < READ_LATENCY; i++) begin
      in_flight = in_flight + IW'(tag_q[i]);
    end
  end

  // Words requested but not yet consumed must fit in the FIFO, so a push can never overflow.
  assign occupancy = 32'(in_flight) + 32'(fifo_count);
  assign credit    = occupancy < 32'(FIFO_DEPTH);
  assign grant     = vga_flag && done_vga;
  assign last_req  = (hcount_q == H_LAST) && (vcount_q == V_LAST);
  assign push      = tag_q[READ_LATENCY-1];
  assign pop       = pix_ready && pix_valid;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (frame_start) begin
      state_d = FETCH;
    end else begin
      case (state_q)
        IDLE:    state_d = IDLE;
        FETCH:   if (grant && last_req) state_d = DRAIN;
        DRAIN:   state_d = DRAIN;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    vga_flag = (state_q == FETCH) && !frame_start && credit;
  end

  always_comb begin
    hcount_d    = hcount_q;
    vcount_d    = vcount_q;
    tag_d       = tag_q;
    underflow_d = underflow_q;
    if (frame_start) begin
      hcount_d    = '0;
      vcount_d    = '0;
      tag_d       = '0;
      underflow_d = 1'b0;
    end else begin
      tag_d = (tag_q << 1) | READ_LATENCY'(grant);
      if (grant) begin
        if (hcount_q == H_LAST) begin
          hcount_d = '0;
          vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + LOG_VCOUNT'(1);
        end else begin
          hcount_d = hcount_q + LOG_HCOUNT'(2);
        end
      end
      if (pix_ready && !pix_valid) begin
        underflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hcount_q    <= '0;
      vcount_q    <= '0;
      tag_q       <= '0;
      underflow_q <= 1'b0;
    end else begin
      hcount_q    <= hcount_d;
      vcount_q    <= vcount_d;
      tag_q       <= tag_d;
      underflow_q <= underflow_d;
    end
  end

  pixel_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clock  (clock),
    .reset_n(reset_n),
    .clear  (frame_start),
    .push   (push),
    .pop    (pop),
    .din    (vga_pixel),
    .dout   (pix_data),
    .count  (fifo_count),
    .empty  (fifo_empty)
  );

  assign pix_valid = !fifo_empty;
  assign hcount    = hcount_q;
  assign vcount    = vcount_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_vga_fetcher.sv
// Randomized scoreboard bench for vga_fetcher on a small 8x4 image.
// The reference model tracks outstanding requests, pixel coordinates and returned words.
module tb_vga_fetcher;
  import vga_fetcher_pkg::*;

  localparam int DEPTH = 8;
  localparam int RL    = 2;
  localparam int W     = 8;
  localparam int H     = 4;
  localparam int NTAB  = 1024;

  typedef struct {
    logic [LOG_MEM-1:0] data;
    int                 rdy;
  } exp_word_t;

  logic                  clock = 1'b0;
  logic                  reset_n = 1'b0;
  logic                  frame_start = 1'b0;
  logic                  vga_flag;
  logic                  done_vga = 1'b0;
  logic [LOG_HCOUNT-1:0] hcount;
  logic [LOG_VCOUNT-1:0] vcount;
  logic [LOG_MEM-1:0]    vga_pixel = '0;
  logic                  pix_ready = 1'b0;
  logic [LOG_MEM-1:0]    pix_data;
  logic                  pix_valid;
  logic                  underflow;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [LOG_MEM-1:0] pix_tab [NTAB];

  exp_word_t          sb[$];
  bit                 m_fetch = 0;
  bit                 m_under = 0;
  int                 m_x = 0;
  int                 m_y = 0;
  int                 frame_grants = 0;
  logic [LOG_MEM-1:0] m_last = '0;

  vga_fetcher #(
    .FIFO_DEPTH  (DEPTH),
    .READ_LATENCY(RL),
    .IMG_W       (W),
    .IMG_H       (H)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .frame_start(frame_start),
    .vga_flag   (vga_flag),
    .done_vga   (done_vga),
    .hcount     (hcount),
    .vcount     (vcount),
    .vga_pixel  (vga_pixel),
    .pix_ready  (pix_ready),
    .pix_data   (pix_data),
    .pix_valid  (pix_valid),
    .underflow  (underflow)
  );

  always #5 clock = ~clock;

  task automatic check_output(input string name, input longint unsigned act,
                              input longint unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic apply_stimulus(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      cyc++;
      #1;
      vga_pixel = pix_tab[cyc % NTAB];
    end
  endtask

  task automatic pulse_frame_start();
    frame_start = 1'b1;
    apply_stimulus(1);
    frame_start = 1'b0;
  endtask

  // Reference model: each cycle predicts handshake outputs, then advances on observed inputs.
  always @(negedge clock) begin
    bit                 exp_valid;
    bit                 exp_flag;
    logic [LOG_MEM-1:0] exp_data;
    if (!reset_n) begin
      sb.delete();
      m_fetch      = 0;
      m_under      = 0;
      m_x          = 0;
      m_y          = 0;
      frame_grants = 0;
      m_last       = '0;
    end else begin
      exp_valid = (sb.size() > 0) && (sb[0].rdy <= cyc);
      exp_flag  = m_fetch && !frame_start && (sb.size() < DEPTH);
      exp_data  = exp_valid ? sb[0].data : m_last;
      check_output("vga_flag", vga_flag, exp_flag);
      check_output("pix_valid", pix_valid, exp_valid);
      check_output("underflow", underflow, m_under);
      check_output("pix_data", pix_data, exp_data);
      if (sb.size() > DEPTH) begin
        check_output("fifo_overflow", sb.size(), DEPTH);
      end
      if (pix_ready) begin
        if (exp_valid) void'(sb.pop_front());
        else m_under = 1;
      end
      if (exp_flag && done_vga) begin
        check_output("hcount", hcount, m_x);
        check_output("vcount", vcount, m_y);
        sb.push_back('{data: pix_tab[(cyc + RL) % NTAB], rdy: cyc + RL + 1});
        frame_grants++;
        m_x += 2;
        if (m_x == W) begin
          m_x = 0;
          m_y++;
          if (m_y == H) begin
            m_y     = 0;
            m_fetch = 0;
          end
        end
      end
      m_last = exp_data;
      if (frame_start) begin
        sb.delete();
        m_fetch      = 1;
        m_under      = 0;
        m_x          = 0;
        m_y          = 0;
        frame_grants = 0;
      end
    end
  end

  initial begin
    for (int i = 0; i < NTAB; i++) pix_tab[i] = LOG_MEM'($urandom);
    $display("[TB] starting vga_fetcher bench");

    // Reset, with the display pulling from the very first cycle.
    apply_stimulus(3);
    check_output("reset_flag", vga_flag, 0);
    check_output("reset_valid", pix_valid, 0);
    check_output("reset_pix_data", pix_data, 0);
    reset_n   = 1'b1;
    pix_ready = 1'b1;
    apply_stimulus(6);
    @(negedge clock);
    check_output("underflow_sticky", underflow, 1);

    // Credits: nobody pops, grants always given.
    pix_ready = 1'b0;
    pulse_frame_start();
    @(negedge clock);
    check_output("underflow_cleared", underflow, 0);
    done_vga = 1'b1;
    apply_stimulus(20);
    @(negedge clock);
    check_output("credit_grants", frame_grants, DEPTH);
    check_output("credit_flag_low", vga_flag, 0);

    // Drain to the end of the frame, then stay quiet.
    pix_ready = 1'b1;
    apply_stimulus(40);
    @(negedge clock);
    check_output("frame_grants", frame_grants, (W / 2) * H);
    check_output("drain_flag_low", vga_flag, 0);
    apply_stimulus(10);

    // Restart the frame while two reads are in flight.
    pix_ready = 1'b0;
    pulse_frame_start();
    apply_stimulus(3);
    frame_start = 1'b1;
    apply_stimulus(1);
    frame_start = 1'b0;
    done_vga    = 1'b0;
    @(negedge clock);
    check_output("restart_valid", pix_valid, 0);
    check_output("restart_hcount", hcount, 0);
    check_output("restart_vcount", vcount, 0);
    apply_stimulus(6);
    @(negedge clock);
    check_output("restart_no_stale", pix_valid, 0);

    // Random traffic with occasional frame restarts.
    for (int i = 0; i < 600; i++) begin
      done_vga    = $urandom_range(0, 3) != 0;
      pix_ready   = $urandom_range(0, 2) != 0;
      frame_start = $urandom_range(0, 60) == 0;
      apply_stimulus(1);
    end
    frame_start = 1'b0;

    // Asynchronous reset in the middle of a frame.
    pulse_frame_start();
    done_vga  = 1'b1;
    pix_ready = 1'b1;
    apply_stimulus(5);
    @(posedge clock);
    #3;
    reset_n = 1'b0;
    #1;
    check_output("async_flag", vga_flag, 0);
    check_output("async_hcount", hcount, 0);
    check_output("async_vcount", vcount, 0);
    check_output("async_valid", pix_valid, 0);
    check_output("async_underflow", underflow, 0);
    check_output("async_pix_data", pix_data, 0);
    cyc++;
    apply_stimulus(2);
    reset_n = 1'b1;
    apply_stimulus(10);
    @(negedge clock);
    check_output("post_reset_idle", vga_flag, 0);
    pulse_frame_start();
    apply_stimulus(30);
    @(negedge clock);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_fetcher.md
VGA_FETCHER -- requirements
Module: vga_fetcher

Interface
REQ-001 Parameter FIFO_DEPTH, default 8: pixel-word FIFO depth; power of two, minimum 4.
REQ-002 Parameter READ_LATENCY, default 2: cycles from done_vga high to the word on vga_pixel; equals the arbiter read-queue length.
REQ-003 Parameter IMG_W, default 640: image width in pixels; even.
REQ-004 Parameter IMG_H, default 480: image height in lines.
REQ-005 Port clock, input, 1: sole clock; all state on its rising edge.
REQ-006 Port reset_n, input, 1: reset, asynchronous and active-low.
REQ-007 Port frame_start, input, 1: one-cycle pulse that restarts fetching at pixel (0,0).
REQ-008 Port vga_flag, output, 1: read request to the memory arbiter.
REQ-009 Port done_vga, input, 1: arbiter grant; the request was accepted this cycle.
REQ-010 Port hcount, output, LOG_HCOUNT: request x coordinate; always even.
REQ-011 Port vcount, output, LOG_VCOUNT: request y coordinate.
REQ-012 Port vga_pixel, input, LOG_MEM: arbiter read data; holds stale values when not tagged.
REQ-013 Port pix_ready, input, 1: display pops one word this cycle.
REQ-014 Port pix_data, output, LOG_MEM: FIFO head word (two pixels).
REQ-015 Port pix_valid, output, 1: FIFO not empty.
REQ-016 Port underflow, output, 1: sticky; pix_ready was seen with the FIFO empty.

Function
REQ-017 Credits: vga_flag SHALL be high only when in_flight + fifo_count < FIFO_DEPTH, state is FETCH, and frame_start is low.
REQ-018 While vga_flag is high, hcount/vcount SHALL hold until done_vga; requests are never withdrawn once raised unless frame_start or reset occurs.
REQ-019 done_vga with vga_flag high SHALL advance hcount by 2; from IMG_W-2 it SHALL wrap to 0 and increment vcount.
REQ-020 Each grant SHALL enter a READ_LATENCY-deep tag shift register; a tag exiting it SHALL write vga_pixel into the FIFO in that same cycle.
REQ-021 in_flight SHALL equal the number of set tags, range 0..READ_LATENCY.
REQ-022 FSM states SHALL be IDLE, FETCH and DRAIN.
  - IDLE -> FETCH on frame_start.
  - FETCH -> DRAIN on the grant of (IMG_W-2, IMG_H-1).
  - DRAIN -> FETCH on frame_start; no requests are issued in DRAIN.
REQ-023 frame_start in any state SHALL clear the FIFO, tags, coordinates and underflow, and enter FETCH next cycle; a grant in the same cycle SHALL be discarded.
REQ-024 Pop: pix_ready with pix_valid high SHALL advance the head next cycle; a simultaneous push and pop SHALL leave fifo_count unchanged.
REQ-025 pix_ready with pix_valid low SHALL set underflow; pix_data holds its last value.
REQ-026 A FIFO push when full SHALL be impossible by construction (REQ-017); the bench asserts it.
REQ-027 Coordinate arithmetic SHALL be unsigned with no overflow past IMG_W-2 / IMG_H-1.

Reset
REQ-028 When reset_n is low, the block SHALL asynchronously force:
  - state IDLE;
  - vga_flag, pix_valid and underflow to 0;
  - hcount, vcount and pix_data to 0;
  - FIFO pointers and tags cleared.
REQ-029 The first rising clock edge after reset_n deasserts SHALL leave all outputs at their reset values; fetching starts only on frame_start.

Structure
REQ-030 LOG_MEM, LOG_HCOUNT, LOG_VCOUNT, IMAGE_WIDTH_D2 and IMAGE_LENGTH SHALL come from the shared params.v; FSM encodings stay local.
REQ-031 The FIFO SHALL be a sub-module pixel_fifo (synchronous, FIFO_DEPTH x LOG_MEM, show-ahead head, count output).

Verification
REQ-032 Scenario: reset, frame_start, done_vga tied high, vga_pixel = cycle count -> FIFO words equal the values at grant+2; hcount sequence 0,2,4...
REQ-033 Scenario: pix_ready low, done_vga always high -> exactly 8 grants, then vga_flag low; no overflow assertion fires.
REQ-034 Scenario: IMG_W=8, IMG_H=2 -> grants at (0,0)..(6,0),(0,1)..(6,1), then DRAIN; vga_flag stays low until the next frame_start.
REQ-035 Scenario: frame_start coincides with a grant and 2 tags in flight -> FIFO empty the next cycle, no stale writes, hcount=0 and vcount=0.
REQ-036 Scenario: pix_ready high from cycle 0 after reset -> underflow=1 and sticky; cleared by frame_start.
REQ-037 Scenario: reset_n pulsed low mid-FETCH between clock edges -> outputs zero immediately; no request until the next frame_start.
